// File: rtl/decode_queue_pkg.sv
// Shared control/instruction definitions for the decode queue: MIPS opcode/funct
// constants, branch-flag bit positions, control word encodings and the queue entry.
package decode_queue_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RI_BLTZ   = 5'h00;
    localparam logic [4:0] RI_BGEZ   = 5'h01;
    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

    // Bit positions inside control_t.branch
    localparam int BR_EQ  = 0;
    localparam int BR_NE  = 1;
    localparam int BR_LEZ = 2;
    localparam int BR_GTZ = 3;
    localparam int BR_LTZ = 4;
    localparam int BR_GEZ = 5;

    typedef enum logic [4:0] {
        ALU_OP_NOP, ALU_OP_PLUS, ALU_OP_MINUS, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
        ALU_OP_NOR, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA,
        ALU_OP_LUI, ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU,
        ALU_OP_MTHI, ALU_OP_MTLO
    } alu_op_t;

    typedef enum logic [1:0] {REG_DST_RT, REG_DST_RD, REG_DST_RA, REG_DST_HILO} reg_dst_t;
    typedef enum logic [1:0] {SRC_B_REG, SRC_B_SEXT, SRC_B_ZEXT} src_b_t;
    typedef enum logic [2:0] {VAL_ALU, VAL_MEM, VAL_PC8, VAL_HI, VAL_LO} val_t;
    typedef enum logic [1:0] {MEM_W, MEM_B, MEM_H} mem_size_t;

    // All-zero word is the NOP control word
    typedef struct packed {
        alu_op_t   alu_op;
        logic      shamt_a;
        src_b_t    src_b;
        logic      reg_write_en;
        reg_dst_t  reg_dst;
        val_t      val_src;
        logic      mem_read;
        logic      mem_write;
        mem_size_t mem_size;
        logic      mem_unsigned;
        logic [5:0] branch;
        logic      jump;
        logic      jump_reg;
        logic      hilo_write_en;
    } control_t;

    localparam control_t CTRL_NOP = '0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        control_t    ctrl;
        logic        illegal;
    } entry_t;

    function automatic control_t ctrl_word(alu_op_t op, src_b_t b, logic we, reg_dst_t dst, val_t v);
        control_t c;
        c              = CTRL_NOP;
        c.alu_op       = op;
        c.src_b        = b;
        c.reg_write_en = we;
        c.reg_dst      = dst;
        c.val_src      = v;
        return c;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// instr_decoder: combinational MIPS decode to control_t plus an illegal flag.
// MULT/MULTU/MFHI/MFLO/MTHI/MTLO are legal only when DECODE_QUEUE_HILO_EN is defined.
module instr_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0] instr,
    output control_t    ctrl,
    output logic        illegal
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        if (instr != 32'h0) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_SLL:  begin ctrl = ctrl_word(ALU_OP_SLL, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU); ctrl.shamt_a = 1'b1; end
                        FN_SRL:  begin ctrl = ctrl_word(ALU_OP_SRL, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU); ctrl.shamt_a = 1'b1; end
                        FN_SRA:  begin ctrl = ctrl_word(ALU_OP_SRA, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU); ctrl.shamt_a = 1'b1; end
                        FN_SLLV: ctrl = ctrl_word(ALU_OP_SLL, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_SRLV: ctrl = ctrl_word(ALU_OP_SRL, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_SRAV: ctrl = ctrl_word(ALU_OP_SRA, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_JR:   ctrl.jump_reg = 1'b1;
                        FN_JALR: begin ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RD, VAL_PC8); ctrl.jump_reg = 1'b1; end
                        FN_DIV:  begin ctrl = ctrl_word(ALU_OP_DIV, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
                        FN_DIVU: begin ctrl = ctrl_word(ALU_OP_DIVU, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
`ifdef DECODE_QUEUE_HILO_EN
                        FN_MULT:  begin ctrl = ctrl_word(ALU_OP_MULT, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
                        FN_MULTU: begin ctrl = ctrl_word(ALU_OP_MULTU, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
                        FN_MTHI:  begin ctrl = ctrl_word(ALU_OP_MTHI, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
                        FN_MTLO:  begin ctrl = ctrl_word(ALU_OP_MTLO, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); ctrl.hilo_write_en = 1'b1; end
                        FN_MFHI:  ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RD, VAL_HI);
                        FN_MFLO:  ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RD, VAL_LO);
`endif
                        FN_ADD, FN_ADDU: ctrl = ctrl_word(ALU_OP_PLUS, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_SUB, FN_SUBU: ctrl = ctrl_word(ALU_OP_MINUS, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_AND:  ctrl = ctrl_word(ALU_OP_AND, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_OR:   ctrl = ctrl_word(ALU_OP_OR, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_XOR:  ctrl = ctrl_word(ALU_OP_XOR, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_NOR:  ctrl = ctrl_word(ALU_OP_NOR, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_SLT:  ctrl = ctrl_word(ALU_OP_SLT, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        FN_SLTU: ctrl = ctrl_word(ALU_OP_SLTU, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU);
                        default: illegal = 1'b1;
                    endcase
                end
                OP_REGIMM: begin
                    case (rt)
                        RI_BLTZ:   ctrl.branch[BR_LTZ] = 1'b1;
                        RI_BGEZ:   ctrl.branch[BR_GEZ] = 1'b1;
                        RI_BLTZAL: begin ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RA, VAL_PC8); ctrl.branch[BR_LTZ] = 1'b1; end
                        RI_BGEZAL: begin ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RA, VAL_PC8); ctrl.branch[BR_GEZ] = 1'b1; end
                        default:   illegal = 1'b1;
                    endcase
                end
                OP_J:     ctrl.jump = 1'b1;
                OP_JAL:   begin ctrl = ctrl_word(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RA, VAL_PC8); ctrl.jump = 1'b1; end
                OP_BEQ:   ctrl.branch[BR_EQ]  = 1'b1;
                OP_BNE:   ctrl.branch[BR_NE]  = 1'b1;
                OP_BLEZ:  ctrl.branch[BR_LEZ] = 1'b1;
                OP_BGTZ:  ctrl.branch[BR_GTZ] = 1'b1;
                OP_ADDI, OP_ADDIU: ctrl = ctrl_word(ALU_OP_PLUS, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_SLTI:  ctrl = ctrl_word(ALU_OP_SLT, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_SLTIU: ctrl = ctrl_word(ALU_OP_SLTU, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_ANDI:  ctrl = ctrl_word(ALU_OP_AND, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_ORI:   ctrl = ctrl_word(ALU_OP_OR, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_XORI:  ctrl = ctrl_word(ALU_OP_XOR, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_LUI:   ctrl = ctrl_word(ALU_OP_LUI, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU);
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    ctrl = ctrl_word(ALU_OP_PLUS, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_MEM);
                    ctrl.mem_read     = 1'b1;
                    ctrl.mem_size     = (opcode == OP_LW) ? MEM_W :
                                        (opcode == OP_LH || opcode == OP_LHU) ? MEM_H : MEM_B;
                    ctrl.mem_unsigned = (opcode == OP_LBU || opcode == OP_LHU);
                end
                OP_SB, OP_SH, OP_SW: begin
                    ctrl = ctrl_word(ALU_OP_PLUS, SRC_B_SEXT, 1'b0, REG_DST_RT, VAL_ALU);
                    ctrl.mem_write = 1'b1;
                    ctrl.mem_size  = (opcode == OP_SW) ? MEM_W : (opcode == OP_SH) ? MEM_H : MEM_B;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: instructions are decoded on enqueue and presented up to ISSUE_WIDTH
// per cycle in head order. Optional HI/LO decode is selected by DECODE_QUEUE_HILO_EN.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_instr,
    input  logic [31:0]                       in_pc,
    input  logic                              flush,
    output logic [ISSUE_WIDTH-1:0]            out_valid,
    output logic [ISSUE_WIDTH-1:0][31:0]      out_instr,
    output logic [ISSUE_WIDTH-1:0][31:0]      out_pc,
    output control_t [ISSUE_WIDTH-1:0]        out_ctrl,
    output logic [ISSUE_WIDTH-1:0]            out_illegal,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  out_take,
    output logic [$clog2(DEPTH+1)-1:0]        count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    control_t         dec_ctrl_p0;
    logic             dec_illegal_p0;
    logic             vld_p0;
    logic [CNT_W-1:0] take_ext;
    logic [CNT_W-1:0] taken;

    instr_decoder u_decoder (
        .instr   (in_instr),
        .ctrl    (dec_ctrl_p0),
        .illegal (dec_illegal_p0)
    );

    // in_ready looks only at the registered count: a same-cycle take does not open space
    assign in_ready = (count < CNT_W'(DEPTH));
    assign vld_p0   = in_valid && in_ready;
    assign take_ext = CNT_W'(out_take);
    assign taken    = (take_ext > count) ? count : take_ext;

    // Stage p0 -> storage: entry data is never reset, only the pointers and count
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem[tail] <= '{instr: in_instr, pc: in_pc, ctrl: dec_ctrl_p0, illegal: dec_illegal_p0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(taken);
            tail  <= tail + PTR_W'(vld_p0);
            count <= count + CNT_W'(vld_p0) - taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (take_ext <= count);
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            entry_t slot;
            slot           = mem[head + PTR_W'(k)];
            out_valid[k]   = (count > CNT_W'(k));
            out_instr[k]   = out_valid[k] ? slot.instr   : 32'h0;
            out_pc[k]      = out_valid[k] ? slot.pc      : 32'h0;
            out_ctrl[k]    = out_valid[k] ? slot.ctrl    : CTRL_NOP;
            out_illegal[k] = out_valid[k] ? slot.illegal : 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed steps then random traffic against a
// queue-based reference model with a table of known instruction decodes.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int IW    = 2;

    logic                 clk = 1'b0;
    logic                 reset, in_valid, in_ready, flush;
    logic [31:0]          in_instr, in_pc;
    logic [IW-1:0]        out_valid, out_illegal;
    logic [IW-1:0][31:0]  out_instr, out_pc;
    control_t [IW-1:0]    out_ctrl;
    logic [1:0]           out_take;
    logic [2:0]           count;

    decode_queue #(.DEPTH(DEPTH), .ISSUE_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .out_illegal(out_illegal), .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; control_t ctrl; logic illegal; } tmpl_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; control_t ctrl; logic illegal; } ent_t;

    tmpl_t tbl[$];
    ent_t  model[$];
    int    compared   = 0;
    int    mismatched = 0;

    function automatic control_t cw(alu_op_t op, src_b_t b, logic we, reg_dst_t d, val_t v);
        control_t c;
        c = '0;
        c.alu_op = op; c.src_b = b; c.reg_write_en = we; c.reg_dst = d; c.val_src = v;
        return c;
    endfunction

    function automatic void add(logic [31:0] instr, control_t c, logic ill);
        tmpl_t t;
        t.instr = instr; t.ctrl = c; t.illegal = ill;
        tbl.push_back(t);
    endfunction

    task automatic lookup(input logic [31:0] instr, output control_t c, output logic ill);
        c = 'x; ill = 1'bx;
        foreach (tbl[i]) if (tbl[i].instr == instr) begin c = tbl[i].ctrl; ill = tbl[i].illegal; end
    endtask

    task automatic build_table();
        control_t c;
        add(32'h24010005, cw(ALU_OP_PLUS, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_ALU), 1'b0); // ADDIU
        add(32'h00221821, cw(ALU_OP_PLUS, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU), 1'b0);  // ADDU
        c = cw(ALU_OP_SLL, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU); c.shamt_a = 1'b1;
        add(32'h00011100, c, 1'b0);                                                      // SLL
        add(32'h00611007, cw(ALU_OP_SRA, SRC_B_REG, 1'b1, REG_DST_RD, VAL_ALU), 1'b0);   // SRAV
        c = '0; c.jump_reg = 1'b1; add(32'h03E00008, c, 1'b0);                           // JR
        c = cw(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RD, VAL_PC8); c.jump_reg = 1'b1;
        add(32'h0040F809, c, 1'b0);                                                      // JALR
        c = cw(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RA, VAL_PC8); c.jump = 1'b1;
        add(32'h0C000010, c, 1'b0);                                                      // JAL
        c = cw(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RA, VAL_PC8); c.branch[BR_GEZ] = 1'b1;
        add(32'h04310004, c, 1'b0);                                                      // BGEZAL
        c = '0; c.branch[BR_LTZ] = 1'b1; add(32'h04200004, c, 1'b0);                     // BLTZ
        c = '0; c.branch[BR_EQ]  = 1'b1; add(32'h10220004, c, 1'b0);                     // BEQ
        c = '0; c.branch[BR_GTZ] = 1'b1; add(32'h1C200004, c, 1'b0);                     // BGTZ
        add(32'h3C011234, cw(ALU_OP_LUI, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU), 1'b0);  // LUI
        add(32'h342100FF, cw(ALU_OP_OR, SRC_B_ZEXT, 1'b1, REG_DST_RT, VAL_ALU), 1'b0);   // ORI
        add(32'h2C220010, cw(ALU_OP_SLTU, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_ALU), 1'b0); // SLTIU
        c = cw(ALU_OP_PLUS, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_MEM); c.mem_read = 1'b1; c.mem_size = MEM_W;
        add(32'h8C220008, c, 1'b0);                                                      // LW
        c = cw(ALU_OP_PLUS, SRC_B_SEXT, 1'b1, REG_DST_RT, VAL_MEM); c.mem_read = 1'b1;
        c.mem_size = MEM_B; c.mem_unsigned = 1'b1;
        add(32'h90220003, c, 1'b0);                                                      // LBU
        c = cw(ALU_OP_PLUS, SRC_B_SEXT, 1'b0, REG_DST_RT, VAL_ALU); c.mem_write = 1'b1; c.mem_size = MEM_B;
        add(32'hA0220001, c, 1'b0);                                                      // SB
        c = cw(ALU_OP_DIVU, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); c.hilo_write_en = 1'b1;
        add(32'h0022001B, c, 1'b0);                                                      // DIVU
        add(32'h00000000, '0, 1'b0);                                                     // all-zero NOP
        add(32'hFC000000, '0, 1'b1);                                                     // opcode 0x3F
        add(32'h0022183F, '0, 1'b1);                                                     // bad funct
        add(32'h04250004, '0, 1'b1);                                                     // bad REGIMM
`ifdef DECODE_QUEUE_HILO_EN
        add(32'h00001010, cw(ALU_OP_NOP, SRC_B_REG, 1'b1, REG_DST_RD, VAL_HI), 1'b0);    // MFHI
        c = cw(ALU_OP_MULT, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); c.hilo_write_en = 1'b1;
        add(32'h00220018, c, 1'b0);                                                      // MULT
        c = cw(ALU_OP_MTLO, SRC_B_REG, 1'b0, REG_DST_HILO, VAL_ALU); c.hilo_write_en = 1'b1;
        add(32'h00200013, c, 1'b0);                                                      // MTLO
`else
        add(32'h00001010, '0, 1'b1);
        add(32'h00220018, '0, 1'b1);
        add(32'h00200013, '0, 1'b1);
`endif
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [IW-1:0]       ev, eil;
        logic [IW-1:0][31:0] ei, ep;
        control_t [IW-1:0]   ec;
        ev = '0; eil = '0; ei = '0; ep = '0; ec = '0;
        for (int k = 0; k < IW; k++) begin
            if (k < model.size()) begin
                ev[k] = 1'b1; ei[k] = model[k].instr; ep[k] = model[k].pc;
                ec[k] = model[k].ctrl; eil[k] = model[k].illegal;
            end
        end
        chk({tag, "/count"},     128'(count),       128'(model.size()));
        chk({tag, "/in_ready"},  128'(in_ready),    128'(model.size() < DEPTH));
        chk({tag, "/out_valid"}, 128'(out_valid),   128'(ev));
        chk({tag, "/out_instr"}, 128'(out_instr),   128'(ei));
        chk({tag, "/out_pc"},    128'(out_pc),      128'(ep));
        chk({tag, "/out_ctrl"},  128'(out_ctrl),    128'(ec));
        chk({tag, "/illegal"},   128'(out_illegal), 128'(eil));
    endtask

    // One clock: model follows the queue rules on the inputs held across the edge
    task automatic cycle(input string tag);
        ent_t e;
        int   sz, taken;
        @(posedge clk);
        sz = model.size();
        if (reset || flush) begin
            model.delete();
        end else begin
            taken = (int'(out_take) > sz) ? sz : int'(out_take);
            for (int i = 0; i < taken; i++) void'(model.pop_front());
            if (in_valid && sz < DEPTH) begin
                e.instr = in_instr; e.pc = in_pc;
                lookup(in_instr, e.ctrl, e.illegal);
                model.push_back(e);
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] take, input logic fl, input logic rst);
        in_valid = v; in_instr = instr; in_pc = pc; out_take = take; flush = fl; reset = rst;
    endtask

    initial begin
        logic [31:0] pc;
        int          idx, mx;
        build_table();
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        cycle("reset0");
        cycle("reset1");

        drive(1'b1, 32'h24010005, 32'hBFC00000, 2'd0, 1'b0, 1'b0);
        cycle("addiu");
        chk("addiu/alu_op", 128'(out_ctrl[0].alu_op), 128'(ALU_OP_PLUS));
        chk("addiu/reg_we", 128'(out_ctrl[0].reg_write_en), 128'(1'b1));
        drive(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        cycle("addiu_drain");

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, tbl[i].instr, 32'h00000100 + 32'(4 * i), 2'd0, 1'b0, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 32'h3C011234, 32'h00000110, 2'd2, 1'b0, 1'b0);
        cycle("full_take2");
        chk("full_take2/count2", 128'(count), 128'(2));
        drive(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        cycle("drain");

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, tbl[4 + i].instr, 32'h00001000 + 32'(4 * i), 2'd0, 1'b0, 1'b0);
            cycle("wrap_fill");
        end
        drive(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        cycle("wrap_drain2");
        drive(1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        cycle("wrap_drain1");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, tbl[8 + i].instr, 32'h00001010 + 32'(4 * i), 2'd0, 1'b0, 1'b0);
            cycle("wrap_refill");
        end
        chk("wrap/slot1_pc", 128'(out_pc[1]), 128'(32'h00001010));

        drive(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        cycle("pre_flush");
        chk("pre_flush/count", 128'(count), 128'(2));
        drive(1'b1, 32'h8C220008, 32'h00002000, 2'd0, 1'b0, 1'b0);
        cycle("to_three");
        drive(1'b1, 32'hA0220001, 32'h00002004, 2'd1, 1'b1, 1'b0);
        cycle("flush");

        drive(1'b1, 32'h00000000, 32'h00003000, 2'd0, 1'b0, 1'b0);
        cycle("zero_nop");
        drive(1'b1, 32'hFC000000, 32'h00003004, 2'd0, 1'b0, 1'b0);
        cycle("op3f");
        chk("op3f/illegal1", 128'(out_illegal), 128'(2'b10));
        drive(1'b1, 32'h00001010, 32'h00003008, 2'd2, 1'b0, 1'b0);
        cycle("mfhi_enq");
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        cycle("mfhi");
`ifdef DECODE_QUEUE_HILO_EN
        chk("mfhi/illegal", 128'(out_illegal[0]), 128'(1'b0));
`else
        chk("mfhi/illegal", 128'(out_illegal[0]), 128'(1'b1));
`endif

        pc = 32'h00010000;
        for (int n = 0; n < 3000; n++) begin
            idx = $urandom_range(0, tbl.size() - 1);
            mx  = (model.size() < IW) ? model.size() : IW;
            drive($urandom_range(0, 3) != 0, tbl[idx].instr, pc,
                  2'($urandom_range(0, mx)), $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
            pc = pc + 32'd4;
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
